// File: rtl/regfile_issue_pipe_if.sv
// Purpose: bundles the issue handshake, register-file ports and result port
//          of regfile_issue_pipe.
// Signals:
//   in_valid/in_ready/in_op/in_rd/in_rs1/in_rs2/in_imm : instruction issue
//   rf_raddr1/2, rf_rdata1/2                           : async register reads
//   rf_we/rf_waddr/rf_wdata                            : register write port
//   res_valid/res_ready/res_rd/res_data                : retired result port
//   retired                                            : retired-instruction count
// Modports: slave = the pipe, master = the environment around it.
interface regfile_issue_pipe_if #(
    parameter int unsigned DW   = 8,
    parameter int unsigned AW   = 3,
    parameter int unsigned CNTW = 16
);
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      in_op;
    logic [AW-1:0]   in_rd;
    logic [AW-1:0]   in_rs1;
    logic [AW-1:0]   in_rs2;
    logic [DW-1:0]   in_imm;
    logic [AW-1:0]   rf_raddr1;
    logic [AW-1:0]   rf_raddr2;
    logic [DW-1:0]   rf_rdata1;
    logic [DW-1:0]   rf_rdata2;
    logic            rf_we;
    logic [AW-1:0]   rf_waddr;
    logic [DW-1:0]   rf_wdata;
    logic            res_valid;
    logic            res_ready;
    logic [AW-1:0]   res_rd;
    logic [DW-1:0]   res_data;
    logic [CNTW-1:0] retired;

    modport slave (
        input  in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm,
        input  rf_rdata1, rf_rdata2, res_ready,
        output in_ready, rf_raddr1, rf_raddr2, rf_we, rf_waddr, rf_wdata,
        output res_valid, res_rd, res_data, retired
    );

    modport master (
        output in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm,
        output rf_rdata1, rf_rdata2, res_ready,
        input  in_ready, rf_raddr1, rf_raddr2, rf_we, rf_waddr, rf_wdata,
        input  res_valid, res_rd, res_data, retired
    );
endinterface

// File: rtl/regfile_issue_pipe.sv
// Purpose: in-order two-stage EX/WB ALU pipe in front of an 8x8 2R/1W register
//          file, with EX->issue and WB->issue operand forwarding and a
//          backpressured result port that doubles as the register write port.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous, active-high reset
//   pipe : regfile_issue_pipe_if.slave (issue, register file, result, counter)
module regfile_issue_pipe #(
    parameter int unsigned DW   = 8,
    parameter int unsigned AW   = 3,
    parameter int unsigned CNTW = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    regfile_issue_pipe_if.slave  pipe
);

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_ADDI = 3'b101;
    localparam logic [2:0] OP_LI   = 3'b110;
    localparam logic [2:0] OP_SHL  = 3'b111;

    logic            r_ex_valid;
    logic [2:0]      r_ex_op;
    logic [AW-1:0]   r_ex_rd;
    logic [DW-1:0]   r_ex_a;
    logic [DW-1:0]   r_ex_b;
    logic [DW-1:0]   r_ex_imm;
    logic            r_wb_valid;
    logic [AW-1:0]   r_wb_rd;
    logic [DW-1:0]   r_wb_data;
    logic [CNTW-1:0] r_retired;

    logic            w_wb_en;
    logic            w_fire;
    logic            w_rf_we;
    logic [DW-1:0]   w_ex_result;
    logic [DW-1:0]   w_fwd_a;
    logic [DW-1:0]   w_fwd_b;

    // WB may be overwritten when empty or being drained this cycle
    assign w_wb_en = !r_wb_valid || pipe.res_ready;
    assign w_fire  = pipe.in_valid && w_wb_en;
    assign w_rf_we = r_wb_valid && pipe.res_ready;

    assign pipe.in_ready  = w_wb_en;
    assign pipe.rf_raddr1 = pipe.in_rs1;
    assign pipe.rf_raddr2 = pipe.in_rs2;
    assign pipe.rf_we     = w_rf_we;
    assign pipe.rf_waddr  = r_wb_rd;
    assign pipe.rf_wdata  = r_wb_data;
    assign pipe.res_valid = r_wb_valid;
    assign pipe.res_rd    = r_wb_rd;
    assign pipe.res_data  = r_wb_data;
    assign pipe.retired   = r_retired;

    // ALU on the EX stage contents
    always_comb begin
        w_ex_result = '0;
        case (r_ex_op)
            OP_ADD:  w_ex_result = r_ex_a + r_ex_b;
            OP_SUB:  w_ex_result = r_ex_a - r_ex_b;
            OP_AND:  w_ex_result = r_ex_a & r_ex_b;
            OP_OR:   w_ex_result = r_ex_a | r_ex_b;
            OP_XOR:  w_ex_result = r_ex_a ^ r_ex_b;
            OP_ADDI: w_ex_result = r_ex_a + r_ex_imm;
            OP_LI:   w_ex_result = r_ex_imm;
            OP_SHL:  w_ex_result = r_ex_a << r_ex_b[2:0];
            default: w_ex_result = '0;
        endcase
    end

    // Operand select: youngest in-flight producer wins over the register file
    always_comb begin
        w_fwd_a = pipe.rf_rdata1;
        if (r_ex_valid && (r_ex_rd == pipe.in_rs1)) begin
            w_fwd_a = w_ex_result;
        end else if (r_wb_valid && (r_wb_rd == pipe.in_rs1)) begin
            w_fwd_a = r_wb_data;
        end
    end

    always_comb begin
        w_fwd_b = pipe.rf_rdata2;
        if (r_ex_valid && (r_ex_rd == pipe.in_rs2)) begin
            w_fwd_b = w_ex_result;
        end else if (r_wb_valid && (r_wb_rd == pipe.in_rs2)) begin
            w_fwd_b = r_wb_data;
        end
    end

    // Pipeline registers and retire counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ex_valid <= 1'b0;
            r_ex_op    <= '0;
            r_ex_rd    <= '0;
            r_ex_a     <= '0;
            r_ex_b     <= '0;
            r_ex_imm   <= '0;
            r_wb_valid <= 1'b0;
            r_wb_rd    <= '0;
            r_wb_data  <= '0;
            r_retired  <= '0;
        end else begin
            if (w_fire) begin
                r_ex_valid <= 1'b1;
                r_ex_op    <= pipe.in_op;
                r_ex_rd    <= pipe.in_rd;
                r_ex_a     <= w_fwd_a;
                r_ex_b     <= w_fwd_b;
                r_ex_imm   <= pipe.in_imm;
            end else if (w_wb_en) begin
                r_ex_valid <= 1'b0;
            end
            if (w_wb_en) begin
                r_wb_valid <= r_ex_valid;
                r_wb_rd    <= r_ex_rd;
                r_wb_data  <= w_ex_result;
            end
            if (w_rf_we) begin
                r_retired <= r_retired + CNTW'(1);
            end
        end
    end

endmodule

// File: tb/tb_regfile_issue_pipe.sv
// Directed bench for regfile_issue_pipe with a behavioural register file,
// a write log, and an architectural reference for a random tail.
module tb_regfile_issue_pipe;

    localparam int unsigned DW   = 8;
    localparam int unsigned AW   = 3;
    localparam int unsigned CNTW = 16;

    localparam logic [2:0] ADD  = 3'd0;
    localparam logic [2:0] SUB  = 3'd1;
    localparam logic [2:0] ANDO = 3'd2;
    localparam logic [2:0] ORO  = 3'd3;
    localparam logic [2:0] XORO = 3'd4;
    localparam logic [2:0] ADDI = 3'd5;
    localparam logic [2:0] LI   = 3'd6;
    localparam logic [2:0] SHL  = 3'd7;

    typedef struct packed {
        logic [31:0] cyc;
        logic [2:0]  a;
        logic [7:0]  d;
    } wr_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    regfile_issue_pipe_if #(.DW(DW), .AW(AW), .CNTW(CNTW)) bus ();

    regfile_issue_pipe #(.DW(DW), .AW(AW), .CNTW(CNTW)) dut (
        .clk  (clk),
        .rst  (rst),
        .pipe (bus)
    );

    logic [7:0] rf_mem [8];
    int         cyc = 0;
    wr_t        wlog [$];

    assign bus.rf_rdata1 = rf_mem[bus.rf_raddr1];
    assign bus.rf_rdata2 = rf_mem[bus.rf_raddr2];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.rf_we) begin
            rf_mem[bus.rf_waddr] <= bus.rf_wdata;
            wlog.push_back({32'(cyc), bus.rf_waddr, bus.rf_wdata});
        end
    end

    int n_tests = 0;
    int n_fail  = 0;
    int wbase   = 0;

    logic [7:0]  ref_rf [8];
    logic [10:0] exp_q [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic wr_t log_at(input int k);
        wr_t e;
        e = '1;
        if (wbase + k < wlog.size()) e = wlog[wbase + k];
        return e;
    endfunction

    task automatic chk_count(input string tag, input int n);
        check(tag, 32'(wlog.size() - wbase), 32'(n));
    endtask

    task automatic chk_wr(input string tag, input int k, input logic [2:0] a, input logic [7:0] d);
        wr_t e;
        e = log_at(k);
        check(tag, 32'({e.a, e.d}), 32'({a, d}));
    endtask

    task automatic chk_consec(input string tag, input int k);
        wr_t e0;
        wr_t e1;
        e0 = log_at(k - 1);
        e1 = log_at(k);
        check(tag, e1.cyc - e0.cyc, 32'd1);
    endtask

    task automatic commit_log();
        wbase = wlog.size();
    endtask

    task automatic drive(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                         input logic [2:0] rs2, input logic [7:0] imm);
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_rd    = rd;
        bus.in_rs1   = rs1;
        bus.in_rs2   = rs2;
        bus.in_imm   = imm;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [7:0] ref_alu(input logic [2:0] op, input logic [7:0] a,
                                           input logic [7:0] b, input logic [7:0] imm);
        logic [15:0] wide;
        case (op)
            ADD:     wide = 16'(a) + 16'(b);
            SUB:     wide = 16'(a) + 16'(~b) + 16'd1;
            ANDO:    wide = 16'(a & b);
            ORO:     wide = 16'(a | b);
            XORO:    wide = 16'(a ^ b);
            ADDI:    wide = 16'(a) + 16'(imm);
            LI:      wide = 16'(imm);
            default: wide = 16'(a) * (16'd1 << b[2:0]);
        endcase
        return wide[7:0];
    endfunction

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_op     = '0;
        bus.in_rd     = '0;
        bus.in_rs1    = '0;
        bus.in_rs2    = '0;
        bus.in_imm    = '0;
        bus.res_ready = 1'b1;
        repeat (3) @(negedge clk);

        check("rst_in_ready",  32'(bus.in_ready),  32'd1);
        check("rst_res_valid", 32'(bus.res_valid), 32'd0);
        check("rst_rf_we",     32'(bus.rf_we),     32'd0);
        check("rst_retired",   32'(bus.retired),   32'd0);
        rst = 1'b0;

        // LI/LI/ADD back-to-back: WB and EX forwarding into one instruction
        drive(LI, 3'd1, 3'd0, 3'd0, 8'h05);
        drive(LI, 3'd2, 3'd0, 3'd0, 8'h03);
        drive(ADD, 3'd3, 3'd1, 3'd2, 8'h00);
        idle(3);
        chk_count("t1_count", 3);
        chk_wr("t1_w_r1", 0, 3'd1, 8'h05);
        chk_wr("t1_w_r2", 1, 3'd2, 8'h03);
        chk_wr("t1_w_r3", 2, 3'd3, 8'h08);
        chk_consec("t1_consec1", 1);
        chk_consec("t1_consec2", 2);
        check("t1_retired", 32'(bus.retired), 32'd3);
        commit_log();

        // Subtract wrap and ADDI wrap through EX forward of r5
        drive(SUB, 3'd4, 3'd2, 3'd1, 8'h00);
        drive(LI, 3'd5, 3'd0, 3'd0, 8'hFF);
        drive(ADDI, 3'd5, 3'd5, 3'd0, 8'h01);
        idle(3);
        chk_count("t2_count", 3);
        chk_wr("t2_sub", 0, 3'd4, 8'hFE);
        chk_wr("t2_li",  1, 3'd5, 8'hFF);
        chk_wr("t2_addi", 2, 3'd5, 8'h00);
        check("t2_retired", 32'(bus.retired), 32'd6);
        commit_log();

        // ADDI chain on r1, each one depending on the one in EX
        drive(LI, 3'd1, 3'd0, 3'd0, 8'h00);
        repeat (4) drive(ADDI, 3'd1, 3'd1, 3'd0, 8'h01);
        idle(3);
        chk_count("t3_count", 5);
        for (int k = 0; k < 5; k++) chk_wr($sformatf("t3_chain%0d", k), k, 3'd1, 8'(k));
        for (int k = 1; k < 5; k++) chk_consec($sformatf("t3_consec%0d", k), k);
        check("t3_retired", 32'(bus.retired), 32'd11);
        commit_log();

        // Backpressure with two in flight
        drive(LI, 3'd6, 3'd0, 3'd0, 8'h11);
        drive(LI, 3'd7, 3'd0, 3'd0, 8'h22);
        bus.res_ready = 1'b0;
        bus.in_valid  = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("t4_in_ready%0d", k),  32'(bus.in_ready),  32'd0);
            check($sformatf("t4_rf_we%0d", k),     32'(bus.rf_we),     32'd0);
            check($sformatf("t4_res_valid%0d", k), 32'(bus.res_valid), 32'd1);
            check($sformatf("t4_res_rd%0d", k),    32'(bus.res_rd),    32'd6);
            check($sformatf("t4_res_data%0d", k),  32'(bus.res_data),  32'h11);
            @(negedge clk);
            #1;
        end
        chk_count("t4_no_write_stalled", 0);
        bus.res_ready = 1'b1;
        idle(3);
        chk_count("t4_count", 2);
        chk_wr("t4_w_r6", 0, 3'd6, 8'h11);
        chk_wr("t4_w_r7", 1, 3'd7, 8'h22);
        chk_consec("t4_consec", 1);
        check("t4_retired", 32'(bus.retired), 32'd13);
        commit_log();

        // Reset while two instructions are in flight
        drive(LI, 3'd0, 3'd0, 3'd0, 8'hAA);
        drive(LI, 3'd2, 3'd0, 3'd0, 8'hBB);
        bus.res_ready = 1'b0;
        bus.in_valid  = 1'b0;
        #1;
        check("t5_pre_res_valid", 32'(bus.res_valid), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.res_ready = 1'b1;
        #1;
        check("t5_res_valid", 32'(bus.res_valid), 32'd0);
        check("t5_retired",   32'(bus.retired),   32'd0);
        check("t5_rf_we",     32'(bus.rf_we),     32'd0);
        check("t5_in_ready",  32'(bus.in_ready),  32'd1);
        idle(3);
        chk_count("t5_no_write", 0);
        check("t5_retired_after", 32'(bus.retired), 32'd0);
        commit_log();

        // SHL uses only the low three bits of B
        drive(LI, 3'd1, 3'd0, 3'd0, 8'h81);
        drive(LI, 3'd2, 3'd0, 3'd0, 8'h09);
        drive(SHL, 3'd6, 3'd1, 3'd2, 8'h00);
        idle(3);
        chk_count("t6_count", 3);
        chk_wr("t6_shl", 2, 3'd6, 8'h02);
        check("t6_retired", 32'(bus.retired), 32'd3);
        commit_log();

        // Every opcode with A=0x3C, B=0xA5
        drive(LI, 3'd1, 3'd0, 3'd0, 8'h3C);
        drive(LI, 3'd2, 3'd0, 3'd0, 8'hA5);
        drive(ADD,  3'd3, 3'd1, 3'd2, 8'h00);
        drive(SUB,  3'd3, 3'd1, 3'd2, 8'h00);
        drive(ANDO, 3'd3, 3'd1, 3'd2, 8'h00);
        drive(ORO,  3'd3, 3'd1, 3'd2, 8'h00);
        drive(XORO, 3'd3, 3'd1, 3'd2, 8'h00);
        drive(ADDI, 3'd3, 3'd1, 3'd2, 8'h10);
        drive(LI,   3'd3, 3'd1, 3'd2, 8'h77);
        drive(SHL,  3'd3, 3'd1, 3'd2, 8'h00);
        idle(3);
        chk_count("t7_count", 10);
        chk_wr("t7_add",  2, 3'd3, 8'hE1);
        chk_wr("t7_sub",  3, 3'd3, 8'h97);
        chk_wr("t7_and",  4, 3'd3, 8'h24);
        chk_wr("t7_or",   5, 3'd3, 8'hBD);
        chk_wr("t7_xor",  6, 3'd3, 8'h99);
        chk_wr("t7_addi", 7, 3'd3, 8'h4C);
        chk_wr("t7_li",   8, 3'd3, 8'h77);
        chk_wr("t7_shl",  9, 3'd3, 8'h80);
        check("t7_retired", 32'(bus.retired), 32'd13);
        commit_log();

        // Random tail against an in-order architectural reference
        for (int r = 0; r < 8; r++) begin
            drive(LI, 3'(r), 3'd0, 3'd0, 8'(r * 17 + 1));
            ref_rf[r] = 8'(r * 17 + 1);
        end
        idle(3);
        commit_log();
        for (int it = 0; it < 200; it++) begin
            logic [2:0] op;
            logic [2:0] rd;
            logic [2:0] s1;
            logic [2:0] s2;
            logic [7:0] imm;
            logic [7:0] res;
            bus.res_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (bus.in_ready && ($urandom_range(0, 4) != 0)) begin
                op  = 3'($urandom_range(0, 7));
                rd  = 3'($urandom_range(0, 7));
                s1  = 3'($urandom_range(0, 7));
                s2  = 3'($urandom_range(0, 7));
                imm = 8'($urandom_range(0, 255));
                res = ref_alu(op, ref_rf[s1], ref_rf[s2], imm);
                ref_rf[rd] = res;
                exp_q.push_back({rd, res});
                drive(op, rd, s1, s2, imm);
            end else begin
                idle(1);
            end
        end
        bus.res_ready = 1'b1;
        idle(4);
        chk_count("rnd_count", exp_q.size());
        for (int k = 0; k < exp_q.size(); k++) begin
            logic [10:0] ev;
            ev = exp_q[k];
            chk_wr($sformatf("rnd_w%0d", k), k, ev[10:8], ev[7:0]);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
